// File: rtl/dkong_obj_rom_arb.sv
// Scheduler for one shared single-port 16K x 8 object ROM: four-plane sprite fetches
// interleaved with buffered download writes.
module dkong_obj_rom_arb #(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned FIFO_DEP = 4,
    parameter logic [3:0]  DL_BASE  = 4'hA
) (
    input  logic        CLK_24M,
    input  logic        I_RSTn,
    input  logic        I_FETCH_REQ,
    input  logic [11:0] I_FETCH_AB,
    output logic        O_FETCH_ACK,
    output logic        O_FETCH_VLD,
    output logic [31:0] O_FETCH_DO,
    input  logic [15:0] DL_ADDR,
    input  logic        DL_WR,
    input  logic [7:0]  DL_DATA,
    output logic        O_DL_OVF,
    output logic [13:0] O_MEM_AB,
    output logic [7:0]  O_MEM_DI,
    output logic        O_MEM_WE,
    input  logic [7:0]  I_MEM_DO
);

    localparam int unsigned PW    = $clog2(FIFO_DEP);
    localparam int unsigned PTR_W = PW + 1;

    typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_t;
    typedef struct packed {
        logic [13:0] ab;
        logic [7:0]  data;
    } dl_entry_t;

    // Reset: asserts immediately, releases on the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK_24M or negedge I_RSTn) begin
        if (!I_RSTn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Download write FIFO
    dl_entry_t        fifo_q [FIFO_DEP];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       dl_off;
    logic             dl_hit, fifo_empty, fifo_full, push, pop, ovf_q;
    dl_entry_t        head;

    assign dl_off     = DL_ADDR[15:12] - DL_BASE;
    assign dl_hit     = DL_WR && (dl_off < 4'd4);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // A pop in the same clock frees the slot, so a full FIFO can still accept.
    assign push       = dl_hit && (!fifo_full || pop);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge CLK_24M) begin
        if (push) fifo_q[wr_ptr_q[PW-1:0]] <= {dl_off[1:0], DL_ADDR[11:0], DL_DATA};
    end

    always_ff @(posedge CLK_24M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (dl_hit && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    // Read-return tracking: stage k marks the plane whose address went out k clocks ago.
    logic [RD_LAT:0]      pv_q;
    logic [RD_LAT:0][1:0] pp_q;
    logic [7:0]           b0_q, b1_q, b2_q;
    logic                 issue, last_cap;
    logic [1:0]           issue_plane;

    assign last_cap = pv_q[RD_LAT] && (pp_q[RD_LAT] == 2'd3);

    always_ff @(posedge CLK_24M or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pp_q <= '0;
            b0_q <= 8'h00;
            b1_q <= 8'h00;
            b2_q <= 8'h00;
        end else begin
            pv_q <= {pv_q[RD_LAT-1:0], issue};
            pp_q <= {pp_q[RD_LAT-1:0], issue_plane};
            if (pv_q[RD_LAT]) begin
                case (pp_q[RD_LAT])
                    2'd0:    b0_q <= I_MEM_DO;
                    2'd1:    b1_q <= I_MEM_DO;
                    2'd2:    b2_q <= I_MEM_DO;
                    default: ;
                endcase
            end
        end
    end

    // Arbitration FSM
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic        owe_q, owe_d;
    logic        ack_q, ack_d, vld_q, vld_d, we_q, we_d;
    logic [31:0] do_q, do_d;
    logic [13:0] ab_q, ab_d;
    logic [7:0]  di_q, di_d;

    always_ff @(posedge CLK_24M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 12'h000;
            owe_q   <= 1'b0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            we_q    <= 1'b0;
            do_q    <= 32'h0;
            ab_q    <= 14'h0;
            di_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            owe_q   <= owe_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            we_q    <= we_d;
            do_q    <= do_d;
            ab_q    <= ab_d;
            di_q    <= di_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        owe_d       = owe_q;
        ack_d       = 1'b0;
        we_d        = 1'b0;
        ab_d        = ab_q;
        di_d        = di_q;
        issue       = 1'b0;
        issue_plane = 2'd0;
        pop         = 1'b0;
        vld_d       = last_cap;
        do_d        = last_cap ? {b0_q, b1_q, b2_q, I_MEM_DO} : do_q;
        case (state_q)
            IDLE: begin
                // An owed write beats the renderer; otherwise writes only fill idle slots.
                if (!fifo_empty && (owe_q || !I_FETCH_REQ)) begin
                    state_d = WR;
                    pop     = 1'b1;
                    ab_d    = head.ab;
                    di_d    = head.data;
                    we_d    = 1'b1;
                    owe_d   = 1'b0;
                end else if (I_FETCH_REQ) begin
                    state_d = RD;
                    addr_d  = I_FETCH_AB;
                    cnt_d   = 2'd0;
                    ab_d    = {2'd0, I_FETCH_AB};
                    ack_d   = 1'b1;
                    issue   = 1'b1;
                end
            end
            RD: begin
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d       = 2'(cnt_q + 2'd1);
                    ab_d        = {2'(cnt_q + 2'd1), addr_q};
                    issue       = 1'b1;
                    issue_plane = 2'(cnt_q + 2'd1);
                end
            end
            DRAIN: begin
                if (last_cap) begin
                    state_d = IDLE;
                    owe_d   = !fifo_empty;
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign O_FETCH_ACK = ack_q;
    assign O_FETCH_VLD = vld_q;
    assign O_FETCH_DO  = do_q;
    assign O_DL_OVF    = ovf_q;
    assign O_MEM_AB    = ab_q;
    assign O_MEM_DI    = di_q;
    assign O_MEM_WE    = we_q;

endmodule

// File: tb/tb_dkong_obj_rom_arb.sv
// Bench for dkong_obj_rom_arb: RD_LAT=1 and RD_LAT=3 instances share stimulus, each with its own ROM model.
module tb_dkong_obj_rom_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, dl_wr, mem_init;
    logic [11:0] fab;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;

    logic        ack1, vld1, ovf1, we1, ack3, vld3, ovf3, we3;
    logic [31:0] do1, do3;
    logic [13:0] ab1, ab3;
    logic [7:0]  di1, di3, mdo1, s3a, s3b, s3c;

    dkong_obj_rom_arb #(.RD_LAT(1), .FIFO_DEP(4), .DL_BASE(4'hA)) u1 (
        .CLK_24M(clk), .I_RSTn(rst_n), .I_FETCH_REQ(req), .I_FETCH_AB(fab),
        .O_FETCH_ACK(ack1), .O_FETCH_VLD(vld1), .O_FETCH_DO(do1),
        .DL_ADDR(dl_addr), .DL_WR(dl_wr), .DL_DATA(dl_data), .O_DL_OVF(ovf1),
        .O_MEM_AB(ab1), .O_MEM_DI(di1), .O_MEM_WE(we1), .I_MEM_DO(mdo1));

    dkong_obj_rom_arb #(.RD_LAT(3), .FIFO_DEP(4), .DL_BASE(4'hA)) u3 (
        .CLK_24M(clk), .I_RSTn(rst_n), .I_FETCH_REQ(req), .I_FETCH_AB(fab),
        .O_FETCH_ACK(ack3), .O_FETCH_VLD(vld3), .O_FETCH_DO(do3),
        .DL_ADDR(dl_addr), .DL_WR(dl_wr), .DL_DATA(dl_data), .O_DL_OVF(ovf3),
        .O_MEM_AB(ab3), .O_MEM_DI(di3), .O_MEM_WE(we3), .I_MEM_DO(s3c));

    // ROM models: byte = plane*16 + addr[3:0] until overwritten
    logic [7:0] mem1 [16384];
    logic [7:0] mem3 [16384];

    function automatic logic [7:0] def_byte(input int i);
        logic [13:0] a;
        a = 14'(i);
        return {2'b00, a[13:12], a[3:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) mem1[i] <= def_byte(i);
        end else if (we1) mem1[ab1] <= di1;
        mdo1 <= mem1[ab1];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) mem3[i] <= def_byte(i);
        end else if (we3) mem3[ab3] <= di3;
        s3a <= mem3[ab3];
        s3b <= s3a;
        s3c <= s3b;
    end

    // Event log of u1: 'F' per ACK, 'W' per write (with {ab,di})
    byte         ev [$];
    logic [21:0] wlog [$];
    int          vcnt1 = 0;

    always @(negedge clk) begin
        if (vld1) vcnt1 <= vcnt1 + 1;
        if (ack1) ev.push_back("F");
        if (we1) begin
            ev.push_back("W");
            wlog.push_back({ab1, di1});
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dl(input logic wr, input logic [15:0] a, input logic [7:0] d);
        dl_wr   = wr;
        dl_addr = a;
        dl_data = d;
    endtask

    task automatic do_fetch(input string name, input logic [11:0] a, input logic [31:0] exp);
        bit seen;
        req  = 1'b1;
        fab  = a;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (ack1) seen = 1'b1;
        end
        req = 1'b0;
        chk({name, " ack"}, 32'(seen), 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (vld1) seen = 1'b1;
        end
        chk({name, " vld"}, 32'(seen), 32'd1);
        chk({name, " do"}, do1, exp);
    endtask

    function automatic int count_w(input int from);
        int n = 0;
        for (int i = from; i < ev.size(); i++) if (ev[i] == "W") n++;
        return n;
    endfunction

    typedef struct {
        logic        req;
        logic [11:0] fab;
        logic        e_ack;
        logic [13:0] e_ab;
        logic        e_vld1;
        logic [31:0] e_do1;
        logic        e_vld3;
        logic [31:0] e_do3;
    } vec_t;

    vec_t tv [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        localparam logic [31:0] D5 = 32'h05152535;
        string       exp_s;
        int          base, wb, vc;
        logic [21:0] exp_w [3];

        tv[0] = '{1'b1, 12'h005, 1'b1, 14'h0005, 1'b0, 32'h0, 1'b0, 32'h0};
        tv[1] = '{1'b0, 12'hFFF, 1'b0, 14'h1005, 1'b0, 32'h0, 1'b0, 32'h0};
        tv[2] = '{1'b0, 12'hFFF, 1'b0, 14'h2005, 1'b0, 32'h0, 1'b0, 32'h0};
        tv[3] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b0, 32'h0, 1'b0, 32'h0};
        tv[4] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b0, 32'h0, 1'b0, 32'h0};
        tv[5] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b1, D5,    1'b0, 32'h0};
        tv[6] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b0, D5,    1'b0, 32'h0};
        tv[7] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b0, D5,    1'b1, D5};
        tv[8] = '{1'b0, 12'hFFF, 1'b0, 14'h3005, 1'b0, D5,    1'b0, D5};

        rst_n = 1'b0; req = 1'b0; fab = 12'h000; mem_init = 1'b1;
        set_dl(1'b0, 16'h0000, 8'h00);
        repeat (3) tick();
        chk("rst ack1", 32'(ack1), 32'd0);
        chk("rst vld1", 32'(vld1), 32'd0);
        chk("rst do1", do1, 32'h0);
        chk("rst ovf1", 32'(ovf1), 32'd0);
        chk("rst ab1", 32'(ab1), 32'd0);
        chk("rst di1", 32'(di1), 32'd0);
        chk("rst we1", 32'(we1), 32'd0);
        chk("rst ab3", 32'(ab3), 32'd0);
        mem_init = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();

        // Single fetch on both latencies
        for (int i = 0; i < 9; i++) begin
            req = tv[i].req;
            fab = tv[i].fab;
            tick();
            chk($sformatf("fetch[%0d] ack1", i), 32'(ack1), 32'(tv[i].e_ack));
            chk($sformatf("fetch[%0d] ack3", i), 32'(ack3), 32'(tv[i].e_ack));
            chk($sformatf("fetch[%0d] ab1", i), 32'(ab1), 32'(tv[i].e_ab));
            chk($sformatf("fetch[%0d] ab3", i), 32'(ab3), 32'(tv[i].e_ab));
            chk($sformatf("fetch[%0d] we1", i), 32'(we1), 32'd0);
            chk($sformatf("fetch[%0d] vld1", i), 32'(vld1), 32'(tv[i].e_vld1));
            chk($sformatf("fetch[%0d] do1", i), do1, tv[i].e_do1);
            chk($sformatf("fetch[%0d] vld3", i), 32'(vld3), 32'(tv[i].e_vld3));
            chk($sformatf("fetch[%0d] do3", i), do3, tv[i].e_do3);
        end

        // One download byte into plane 2, then read it back
        set_dl(1'b1, 16'hC123, 8'h5A);
        tick();
        set_dl(1'b0, 16'h0000, 8'h00);
        tick();
        chk("dl we", 32'(we1), 32'd1);
        chk("dl ab", 32'(ab1), 32'h2123);
        chk("dl di", 32'(di1), 32'h5A);
        tick();
        chk("dl we off", 32'(we1), 32'd0);
        do_fetch("dl readback", 12'h123, 32'h03135A33);

        // Held REQ with three writes arriving during the first fetch
        base = ev.size();
        wb   = wlog.size();
        req = 1'b1;
        fab = 12'h040;
        tick();
        chk("fair ack", 32'(ack1), 32'd1);
        set_dl(1'b1, 16'hA010, 8'h11); tick();
        set_dl(1'b1, 16'hB020, 8'h22); tick();
        set_dl(1'b1, 16'hD030, 8'h33); tick();
        set_dl(1'b0, 16'h0000, 8'h00);
        repeat (30) tick();
        req = 1'b0;
        repeat (20) tick();
        exp_s = "FWFWFWF";
        for (int i = 0; i < 7; i++)
            chk($sformatf("fair ev[%0d]", i),
                (ev.size() > base + i) ? 32'(ev[base + i]) : 32'h0, 32'(exp_s[i]));
        chk("fair w count", 32'(count_w(base)), 32'd3);
        exp_w[0] = {14'h0010, 8'h11};
        exp_w[1] = {14'h1020, 8'h22};
        exp_w[2] = {14'h3030, 8'h33};
        for (int i = 0; i < 3; i++)
            chk($sformatf("fair wr[%0d]", i),
                (wlog.size() > wb + i) ? 32'(wlog[wb + i]) : 32'h0, 32'(exp_w[i]));
        chk("fair ovf", 32'(ovf1), 32'd0);

        // Six back-to-back writes into a 4-deep FIFO while a fetch blocks it
        base = ev.size();
        wb   = wlog.size();
        for (int i = 0; i < 6; i++) begin
            set_dl(1'b1, 16'hA100 + 16'(i), 8'h40 + 8'(i));
            if (i == 0) req = 1'b1;
            tick();
            if (i == 0) begin
                chk("ovf ack", 32'(ack1), 32'd1);
                req = 1'b0;
            end
        end
        set_dl(1'b0, 16'h0000, 8'h00);
        chk("ovf set", 32'(ovf1), 32'd1);
        repeat (20) tick();
        chk("ovf w count", 32'(count_w(base)), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovf wr[%0d]", i),
                (wlog.size() > wb + i) ? 32'(wlog[wb + i]) : 32'h0,
                32'({14'h0100 + 14'(i), 8'h40 + 8'(i)}));
        chk("ovf sticky", 32'(ovf1), 32'd1);

        // Writes outside the four-plane window are ignored
        base = ev.size();
        set_dl(1'b1, 16'h8000, 8'h99); tick();
        set_dl(1'b1, 16'h9FFF, 8'h98); tick();
        set_dl(1'b1, 16'hE000, 8'h97); tick();
        set_dl(1'b0, 16'h0000, 8'h00);
        repeat (8) tick();
        chk("ignored w count", 32'(count_w(base)), 32'd0);

        // Reset in the middle of a fetch
        req = 1'b1;
        fab = 12'h005;
        tick();
        chk("rstmid ack", 32'(ack1), 32'd1);
        req = 1'b0;
        tick();
        tick();
        vc = vcnt1;
        rst_n = 1'b0;
        #1;
        chk("rstmid ack1", 32'(ack1), 32'd0);
        chk("rstmid vld1", 32'(vld1), 32'd0);
        chk("rstmid do1", do1, 32'h0);
        chk("rstmid ovf1", 32'(ovf1), 32'd0);
        chk("rstmid ab1", 32'(ab1), 32'd0);
        chk("rstmid di1", 32'(di1), 32'd0);
        chk("rstmid we1", 32'(we1), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("rstmid no vld", 32'(vcnt1), 32'(vc));
        chk("rstmid do after", do1, 32'h0);
        base = ev.size();
        do_fetch("rstmid refetch", 12'h005, D5);
        repeat (8) tick();
        chk("rstmid fifo empty", 32'(count_w(base)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
